// File: rtl/traffic_conflict_monitor.sv
// Receive-side checker for the two-intersection lamp buses.
// Samples all eight heads each clock and checks them for illegal codes,
// conflicting right-of-way, short greens and starved approaches.
// The first fault found latches one record and raises flash_req.
// It also counts completed legal green phases for each intersection.
// Lamp encoding: bit2 red, bit1 yellow, bit0 green.
// Approach index order: f_n=0, f_s=1, f_e=2, f_w=3, s_n=4, s_s=5, s_e=6, s_w=7.
module traffic_conflict_monitor #(
  parameter int MIN_GREEN = 3,
  parameter int MAX_RED   = 40,
  parameter int STARTUP   = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       f_n,
  input  logic [2:0]       f_s,
  input  logic [2:0]       f_e,
  input  logic [2:0]       f_w,
  input  logic [2:0]       s_n,
  input  logic [2:0]       s_s,
  input  logic [2:0]       s_e,
  input  logic [2:0]       s_w,
  output logic             fault,
  output logic             flash_req,
  output logic [2:0]       fault_code,
  output logic [2:0]       fault_src,
  output logic [CNT_W-1:0] phase_cnt_f,
  output logic [CNT_W-1:0] phase_cnt_s,
  output logic [1:0]       state_o
);

  localparam int G_W  = $clog2(MIN_GREEN + 1);
  localparam int R_W  = $clog2(MAX_RED + 1);
  localparam int SC_W = (STARTUP > 1) ? $clog2(STARTUP) : 1;
  localparam logic [G_W-1:0]  MIN_G   = G_W'(MIN_GREEN);
  localparam logic [R_W-1:0]  MAX_R   = R_W'(MAX_RED);
  localparam logic [SC_W-1:0] ST_LAST = SC_W'(STARTUP - 1);

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_MONITOR = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t          state;
  logic [SC_W-1:0] st_cnt;

  // Lamp codes are registered once, and the check runs on that registered copy.
  // samp_vld marks a sample that was taken while the block was already monitoring.
  // Because of this, codes shown during STARTUP can never raise a fault.
  logic [2:0]      lamp    [8];
  logic [2:0]      samp    [8];
  logic            samp_vld;
  logic [G_W-1:0]  g_dwell [8];
  logic [R_W-1:0]  r_dwell [8];
  logic [G_W-1:0]  g_next  [8];
  logic [R_W-1:0]  r_next  [8];

  logic [7:0]       ill_vec, conf_vec, min_vec, max_vec, ok_exit, nonred;
  logic [2:0]       seen;
  logic [CNT_W-1:0] add_f, add_s;
  logic             det;
  logic [2:0]       det_code, det_src;

  // Returns the lowest set index. Inside one fault class, the lowest source wins.
  function automatic logic [2:0] low_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Per-approach classification, next dwell values and priority-encoded fault selection
  always_comb begin
    lamp[0] = f_n; lamp[1] = f_s; lamp[2] = f_e; lamp[3] = f_w;
    lamp[4] = s_n; lamp[5] = s_s; lamp[6] = s_e; lamp[7] = s_w;
    ill_vec  = '0;
    conf_vec = '0;
    min_vec  = '0;
    max_vec  = '0;
    ok_exit  = '0;
    nonred   = '0;
    seen     = '0;
    add_f    = '0;
    add_s    = '0;
    for (int i = 0; i < 8; i++) begin
      ill_vec[i] = !(samp[i] == RED || samp[i] == YELLOW || samp[i] == GREEN);
      nonred[i]  = (samp[i] != RED);
      // g_dwell is non-zero exactly when the previous sample was green.
      min_vec[i] = (samp[i] != GREEN) && (g_dwell[i] != '0) && (g_dwell[i] < MIN_G);
      ok_exit[i] = (samp[i] != GREEN) && (g_dwell[i] == MIN_G);
      max_vec[i] = (samp[i] == RED) && (r_dwell[i] == MAX_R);
      g_next[i]  = (samp[i] != GREEN) ? '0 :
                   (g_dwell[i] == MIN_G) ? g_dwell[i] : g_dwell[i] + 1'b1;
      r_next[i]  = (samp[i] != RED) ? '0 :
                   (r_dwell[i] == MAX_R) ? r_dwell[i] : r_dwell[i] + 1'b1;
    end
    // A conflict is reported against the second non-red approach of its intersection.
    for (int x = 0; x < 2; x++) begin
      seen = '0;
      for (int a = 0; a < 4; a++) begin
        if (nonred[4*x + a]) begin
          if (seen == 3'd1) conf_vec[4*x + a] = 1'b1;
          seen = seen + 3'd1;
        end
      end
    end
    for (int a = 0; a < 4; a++) begin
      add_f = add_f + CNT_W'(ok_exit[a]);
      add_s = add_s + CNT_W'(ok_exit[4 + a]);
    end
    det      = 1'b1;
    det_code = 3'd0;
    det_src  = 3'd0;
    if (|ill_vec) begin
      det_code = 3'd1; det_src = low_idx(ill_vec);
    end else if (|conf_vec) begin
      det_code = 3'd2; det_src = low_idx(conf_vec);
    end else if (|min_vec) begin
      det_code = 3'd3; det_src = low_idx(min_vec);
    end else if (|max_vec) begin
      det_code = 3'd4; det_src = low_idx(max_vec);
    end else begin
      det = 1'b0;
    end
  end

  // Mode FSM: fault record, dwell counters and phase counters. FAULT freezes all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_STARTUP;
      st_cnt      <= '0;
      samp_vld    <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      fault_src   <= '0;
      phase_cnt_f <= '0;
      phase_cnt_s <= '0;
      for (int i = 0; i < 8; i++) begin
        samp[i]    <= RED;
        g_dwell[i] <= '0;
        r_dwell[i] <= '0;
      end
    end else begin
      samp_vld <= (state == ST_MONITOR);
      for (int i = 0; i < 8; i++) samp[i] <= lamp[i];
      case (state)
        ST_STARTUP: begin
          if (st_cnt == ST_LAST) state <= ST_MONITOR;
          else                   st_cnt <= st_cnt + 1'b1;
        end
        ST_MONITOR: begin
          if (samp_vld) begin
            if (det) begin
              state      <= ST_FAULT;
              fault      <= 1'b1;
              fault_code <= det_code;
              fault_src  <= det_src;
            end else begin
              phase_cnt_f <= phase_cnt_f + add_f;
              phase_cnt_s <= phase_cnt_s + add_s;
              for (int i = 0; i < 8; i++) begin
                g_dwell[i] <= g_next[i];
                r_dwell[i] <= r_next[i];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign flash_req = fault;
  assign state_o   = state;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor.
// The driver applies directed lamp vectors and pushes hand-computed expected
// records. A monitor on the falling edge pops each record and compares it.
// Record layout: {state, fault, flash_req, fault_code, fault_src, phase_cnt_f, phase_cnt_s}.
module tb_traffic_conflict_monitor;
  localparam int W = 26;
  localparam logic [23:0] ALL_RED = {8{3'b100}};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] f_n, f_s, f_e, f_w, s_n, s_s, s_e, s_w;
  logic       fault, flash_req;
  logic [2:0] fault_code, fault_src;
  logic [7:0] phase_cnt_f, phase_cnt_s;
  logic [1:0] state_o;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         chk_valid = 1'b0;

  traffic_conflict_monitor dut (
    .clk(clk), .rst(rst),
    .f_n(f_n), .f_s(f_s), .f_e(f_e), .f_w(f_w),
    .s_n(s_n), .s_s(s_s), .s_e(s_e), .s_w(s_w),
    .fault(fault), .flash_req(flash_req),
    .fault_code(fault_code), .fault_src(fault_src),
    .phase_cnt_f(phase_cnt_f), .phase_cnt_s(phase_cnt_s),
    .state_o(state_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] set_code(input logic [23:0] v, input int idx, input logic [2:0] c);
    logic [23:0] r;
    r = v;
    r[3*idx +: 3] = c;
    return r;
  endfunction

  // All red, except one green approach per intersection (-1 means none).
  function automatic logic [23:0] greens(input int fa, input int sa);
    logic [23:0] v;
    v = ALL_RED;
    if (fa >= 0) v = set_code(v, fa, 3'b001);
    if (sa >= 0) v = set_code(v, sa, 3'b001);
    return v;
  endfunction

  // Rotation with 'per' cycles per green. skip_se rotates s over n,s,w only, so s_e stays red.
  function automatic logic [23:0] rot(input int c, input int per, input bit skip_se);
    int fa, sa;
    fa = (c / per) % 4;
    if (!skip_se) sa = 4 + fa;
    else begin
      case ((c / per) % 3)
        0:       sa = 4;
        1:       sa = 5;
        default: sa = 7;
      endcase
    end
    return greens(fa, sa);
  endfunction

  function automatic logic [W-1:0] mk(input int st, input bit f, input int code, input int src,
                                      input int pf, input int ps);
    return {2'(st), f, f, 3'(code), 3'(src), 8'(pf), 8'(ps)};
  endfunction

  // driver tasks
  task automatic cyc(input logic [23:0] v);
    {s_w, s_e, s_s, s_n, f_w, f_e, f_s, f_n} = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_valid = 1'b1;
    @(negedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(ALL_RED);
    rst = 1'b0;
    cyc(ALL_RED);
    cyc(ALL_RED);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (chk_valid) begin
      logic [W-1:0] act, e;
      string nm;
      act = {state_o, fault, flash_req, fault_code, fault_src, phase_cnt_f, phase_cnt_s};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: act=%h with no expected record", act);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s: act st=%0d flt=%0b fl=%0b code=%0d src=%0d pf=%0d ps=%0d | exp st=%0d flt=%0b fl=%0b code=%0d src=%0d pf=%0d ps=%0d",
                   nm, act[25:24], act[23], act[22], act[21:19], act[18:16], act[15:8], act[7:0],
                   e[25:24], e[23], e[22], e[21:19], e[18:16], e[15:8], e[7:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    {s_w, s_e, s_s, s_n, f_w, f_e, f_s, f_n} = ALL_RED;
    cyc(ALL_RED);
    cyc(ALL_RED);
    expect_out("reset_state", mk(0, 0, 0, 0, 0, 0));

    // Two full legal rotations. The extra cycles let the final f_w/s_w exit be counted.
    do_reset();
    expect_out("startup_to_monitor", mk(1, 0, 0, 0, 0, 0));
    for (int c = 0; c < 34; c++) cyc(rot(c, 4, 1'b0));
    expect_out("two_rotations", mk(1, 0, 0, 0, 8, 8));

    // Illegal code on f_e; the record must then ignore later violations.
    do_reset();
    cyc(set_code(ALL_RED, 2, 3'b011));
    cyc(ALL_RED);
    expect_out("illegal_f_e", mk(2, 1, 1, 2, 0, 0));
    cyc(set_code(greens(-1, 4), 7, 3'b010));
    cyc(set_code(ALL_RED, 0, 3'b111));
    cyc(greens(1, 5));
    cyc(ALL_RED);
    expect_out("fault_frozen", mk(2, 1, 1, 2, 0, 0));

    // Conflict in the second intersection: s_n green and s_w yellow.
    do_reset();
    cyc(set_code(greens(-1, 4), 7, 3'b010));
    cyc(ALL_RED);
    expect_out("conflict_s", mk(2, 1, 2, 7, 0, 0));

    // Short green on f_s.
    do_reset();
    cyc(greens(1, -1));
    cyc(greens(1, -1));
    cyc(ALL_RED);
    cyc(ALL_RED);
    expect_out("min_green_short", mk(2, 1, 3, 1, 0, 0));

    // A three-cycle green is legal and counts one phase.
    do_reset();
    for (int c = 0; c < 3; c++) cyc(greens(1, -1));
    cyc(ALL_RED);
    cyc(ALL_RED);
    expect_out("min_green_exact", mk(1, 0, 0, 0, 1, 0));

    // s_e starved. The 41st red sample faults; others keep rotating with 6-cycle greens.
    do_reset();
    for (int c = 0; c < 41; c++) cyc(rot(c, 6, 1'b1));
    expect_out("max_red_before", mk(1, 0, 0, 0, 6, 6));
    cyc(rot(41, 6, 1'b1));
    expect_out("max_red_41", mk(2, 1, 4, 6, 6, 6));

    // 40 red samples on s_e, then green: this is legal.
    do_reset();
    for (int c = 0; c < 40; c++) cyc(rot(c, 6, 1'b1));
    for (int c = 40; c < 44; c++) cyc(greens((c / 6) % 4, 6));
    expect_out("max_red_40_ok", mk(1, 0, 0, 0, 7, 7));

    // Illegal code on s_s in the same cycle as a conflict on f: illegal wins.
    do_reset();
    cyc(set_code(greens(0, -1), 1, 3'b001) ^ 24'h0 | {3'b000, 3'b000, 3'b011, 15'h0});
    cyc(ALL_RED);
    expect_out("illegal_beats_conflict", mk(2, 1, 1, 5, 0, 0));

    // Reset out of FAULT. An illegal code during STARTUP must be ignored.
    rst = 1'b1;
    cyc(ALL_RED);
    expect_out("reset_from_fault", mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    cyc(set_code(ALL_RED, 0, 3'b111));
    expect_out("startup_cycle1", mk(0, 0, 0, 0, 0, 0));
    cyc(set_code(ALL_RED, 0, 3'b111));
    expect_out("startup_done", mk(1, 0, 0, 0, 0, 0));
    cyc(ALL_RED);
    cyc(ALL_RED);
    expect_out("startup_illegal_ignored", mk(1, 0, 0, 0, 0, 0));

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: act=%0d pending records, exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
